// File: rtl/ohs_boost_step_sequencer_if.sv
// Configuration/command and step-output bundle between the AXI register block
// and the boost model step sequencer.
interface ohs_boost_step_sequencer_if #(
    parameter int unsigned PRESC_WIDTH = 16,
    parameter int unsigned PWM_WIDTH   = 16,
    parameter int unsigned STEP_WIDTH  = 32
) ();
    logic [PRESC_WIDTH-1:0] cfg_presc;
    logic [PWM_WIDTH-1:0]   cfg_pwm_period;
    logic [PWM_WIDTH-1:0]   cfg_pwm_duty;
    logic [STEP_WIDTH-1:0]  cfg_steps;
    logic                   cmd_start;
    logic                   cmd_stop;
    logic                   model_ce;
    logic                   S1_pwm;
    logic                   busy;
    logic                   done;
    logic [STEP_WIDTH-1:0]  step_count;

    modport master (
        output cfg_presc, cfg_pwm_period, cfg_pwm_duty, cfg_steps, cmd_start, cmd_stop,
        input  model_ce, S1_pwm, busy, done, step_count
    );

    modport slave (
        input  cfg_presc, cfg_pwm_period, cfg_pwm_duty, cfg_steps, cmd_start, cmd_stop,
        output model_ce, S1_pwm, busy, done, step_count
    );
endinterface

// File: rtl/ohs_boost_step_sequencer.sv
// Step strobe / PWM gate sequencer for the boost level-1 model: prescaled
// model_ce, free-run or burst operation, and a step-based PWM carrier.
module ohs_boost_step_sequencer #(
    parameter int unsigned PRESC_WIDTH = 16,
    parameter int unsigned PWM_WIDTH   = 16,
    parameter int unsigned STEP_WIDTH  = 32
) (
    input  logic                         aclk,
    input  logic                         reset,
    ohs_boost_step_sequencer_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        BURST = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [PRESC_WIDTH-1:0] p_q, pc_q;
    logic [STEP_WIDTH-1:0]  rem_q, cnt_q;
    logic [PWM_WIDTH-1:0]   per_sh_q, duty_sh_q, pwc_q;
    logic                   model_ce_q, s1_q, done_q;

    logic                   start_c, stop_c, issue_c, last_c;
    logic [PWM_WIDTH-1:0]   per_cfg_c;

    // A zero period would never wrap the carrier; clamp it to one step.
    assign per_cfg_c = (bus.cfg_pwm_period == '0) ? PWM_WIDTH'(1) : bus.cfg_pwm_period;

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state and per-cycle control decisions.
    always_comb begin
        state_d = state_q;
        start_c = 1'b0;
        stop_c  = 1'b0;
        issue_c = 1'b0;
        last_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cmd_start && !bus.cmd_stop) begin
                    start_c = 1'b1;
                    state_d = (bus.cfg_steps == '0) ? RUN : BURST;
                end
            end
            RUN, BURST: begin
                if (bus.cmd_stop) begin
                    stop_c  = 1'b1;
                    state_d = IDLE;
                end else if (pc_q == p_q) begin
                    issue_c = 1'b1;
                    if (state_q == BURST && rem_q == STEP_WIDTH'(1)) begin
                        last_c  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Prescaler, step counter, burst counter and PWM carrier.
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            p_q        <= '0;
            pc_q       <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            per_sh_q   <= '0;
            duty_sh_q  <= '0;
            pwc_q      <= '0;
            model_ce_q <= 1'b0;
            s1_q       <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            model_ce_q <= issue_c;
            done_q     <= last_c;
            if (start_c) begin
                p_q       <= bus.cfg_presc;
                rem_q     <= bus.cfg_steps;
                per_sh_q  <= per_cfg_c;
                duty_sh_q <= bus.cfg_pwm_duty;
                pwc_q     <= '0;
                cnt_q     <= '0;
                pc_q      <= '0;
                s1_q      <= 1'b0;
            end else if (stop_c) begin
                pc_q <= '0;
                s1_q <= 1'b0;
            end else if (issue_c) begin
                pc_q  <= '0;
                cnt_q <= cnt_q + STEP_WIDTH'(1);
                s1_q  <= (pwc_q < duty_sh_q);
                // Shadows reload only at the carrier wrap so a period is never torn.
                if (pwc_q == per_sh_q - PWM_WIDTH'(1)) begin
                    pwc_q     <= '0;
                    per_sh_q  <= per_cfg_c;
                    duty_sh_q <= bus.cfg_pwm_duty;
                end else begin
                    pwc_q <= pwc_q + PWM_WIDTH'(1);
                end
                if (state_q == BURST) rem_q <= rem_q - STEP_WIDTH'(1);
            end else if (state_q != IDLE) begin
                pc_q <= pc_q + PRESC_WIDTH'(1);
            end
        end
    end

    assign bus.model_ce   = model_ce_q;
    assign bus.S1_pwm     = s1_q;
    assign bus.done       = done_q;
    assign bus.step_count = cnt_q;
    assign bus.busy       = (state_q != IDLE) | model_ce_q;
endmodule
